instr_fetch_unit: RTL

- Fetch stage directly upstream of the single-cycle datapath.
- Owns the fetch PC and issues requests to instruction memory over a req/gnt/rvalid protocol.
- Buffers returned words in a small in-order FIFO.
- Presents instr_code/instr_pc to the datapath with a valid/ready handshake; supports redirect with flush for branches and jumps.

---
 rtl/instr_fetch_unit_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 75 +++++++
 rtl/instr_fetch_unit.sv | 127 ++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared types, constants and protocol messages for the instruction fetch stage.
package instr_fetch_unit_pkg;

    typedef logic [31:0] instr_word_t;

    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
    localparam instr_word_t NOP_INSTR    = 32'h0000_0013;

    localparam string MSG_RVALID_IDLE =
        "instr_fetch_unit: imem_rvalid with no outstanding request";
    localparam string MSG_REDIRECT_MISALIGNED =
        "instr_fetch_unit: redirect_pc[1:0] nonzero, low bits ignored";

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// In-order instruction buffer with flush; the head word is read combinationally.
module fetch_fifo
    import instr_fetch_unit_pkg::*;
#(
    parameter int  DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  instr_word_t      push_data,
    input  logic             pop,
    input  logic             flush,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output instr_word_t      head_data
);

    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             full;
    logic             do_push;
    logic             do_pop;
    instr_word_t      slot_data [DEPTH];

    assign empty = (count_reg == '0);
    assign full  = (count_reg == CNT_W'(DEPTH));
    assign count = count_reg;

    // A pop frees the slot the full FIFO is about to overwrite, so push+pop at full is legal.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            instr_word_t slot_reg;

            always_ff @(posedge clk) begin
                if (!reset) begin
                    slot_reg <= NOP_INSTR;
                end else if (do_push && wr_ptr_reg == PTR_W'(gi)) begin
                    slot_reg <= push_data;
                end
            end

            assign slot_data[gi] = slot_reg;
        end
    endgenerate

    assign head_data = slot_data[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the fetch PC, issues credit-limited memory requests and
// buffers in-order responses for the datapath, with redirect/flush support.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_VECTOR,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_code,
    output logic [31:0] instr_pc
);

    localparam int             CNT_W        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W:0] CREDIT_LIMIT = (CNT_W + 1)'(FIFO_DEPTH);

    logic [31:0]      fpc_reg;
    logic [31:0]      fpc_next;
    logic [31:0]      dpc_reg;
    logic [31:0]      dpc_next;
    logic [CNT_W-1:0] outstanding_reg;
    logic [CNT_W-1:0] outstanding_next;
    logic [CNT_W-1:0] discard_reg;
    logic [CNT_W-1:0] discard_next;

    logic [CNT_W-1:0] fifo_count;
    logic             fifo_empty;
    instr_word_t      fifo_head;
    logic             fifo_push;
    logic             fifo_pop;
    logic             credit_ok;
    logic             issue;
    logic [31:0]      redirect_target;

    assign redirect_target = word_align(redirect_pc);

    // Every request in flight already owns a buffer slot, so the FIFO can never overflow.
    assign credit_ok = ({1'b0, outstanding_reg} + {1'b0, fifo_count}) < CREDIT_LIMIT;
    assign imem_req  = reset && credit_ok && !redirect_valid;
    assign imem_addr = fpc_reg;
    assign issue     = imem_req && imem_gnt;

    assign instr_valid = reset && !fifo_empty;
    assign instr_code  = instr_valid ? fifo_head : 32'h0;
    assign instr_pc    = dpc_reg;

    assign fifo_pop  = instr_valid && instr_ready && !redirect_valid;
    assign fifo_push = imem_rvalid && (discard_reg == '0) && !redirect_valid;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fetch_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (imem_rdata),
        .pop       (fifo_pop),
        .flush     (redirect_valid),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .head_data (fifo_head)
    );

    always_comb begin
        fpc_next         = fpc_reg;
        dpc_next         = dpc_reg;
        outstanding_next = outstanding_reg;
        discard_next     = discard_reg;

        case ({issue, imem_rvalid})
            2'b10:   outstanding_next = outstanding_reg + CNT_W'(1);
            2'b01:   outstanding_next = outstanding_reg - CNT_W'(1);
            default: outstanding_next = outstanding_reg;
        endcase

        if (redirect_valid) begin
            // Everything still in flight belongs to the abandoned path.
            fpc_next     = redirect_target;
            dpc_next     = redirect_target;
            discard_next = imem_rvalid ? outstanding_reg - CNT_W'(1) : outstanding_reg;
        end else begin
            if (issue) begin
                fpc_next = fpc_reg + 32'd4;
            end
            if (fifo_pop) begin
                dpc_next = dpc_reg + 32'd4;
            end
            if (imem_rvalid && discard_reg != '0) begin
                discard_next = discard_reg - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            fpc_reg         <= RESET_PC;
            dpc_reg         <= RESET_PC;
            outstanding_reg <= '0;
            discard_reg     <= '0;
        end else begin
            fpc_reg         <= fpc_next;
            dpc_reg         <= dpc_next;
            outstanding_reg <= outstanding_next;
            discard_reg     <= discard_next;
        end
    end

    always @(posedge clk) begin
        if (reset) begin
            assert (!(imem_rvalid && outstanding_reg == '0))
                else $error("%s", MSG_RVALID_IDLE);
            assert (!(redirect_valid && redirect_pc[1:0] != 2'b00))
                else $warning("%s", MSG_REDIRECT_MISALIGNED);
        end
    end

endmodule
